iq_dac_output_stage: RTL
========================

// Module: iq_dac_output_stage
// PURPOSE
//  Parametrised successor to the transmitter's fixed 14-bit I/Q output register.
//  Registers NCH I/Q channel pairs to the DAC and formats them as two's complement or offset binary.
//  Adds a post-reset hold-off, a mute with optional soft ramp, a state report and a heartbeat.
//  Sits between the modulator (sine/cosine) and the DAC pins; clocked in the DAC clock domain.
// PARAMETERS
//  DW          14      sample width per I or Q word
//  NCH         1       number of I/Q channel pairs
//  HOLD_CYC    4096    cycles outputs stay at midscale after reset before RUN
//  RAMP_SHIFT  6       ramp length 2^RAMP_SHIFT cycles; unity gain = 2^RAMP_SHIFT
//  HB_BITS     28      heartbeat counter width
// PORTS
//  clk        in   1       DAC-domain clock
//  rst        in   1       reset, synchronous, active-high
//  in_valid   in   1       in_i/in_q hold a new sample
//  in_i       in   NCH*DW  in-phase samples, two's complement; ch0 in LSBs
//  in_q       in   NCH*DW  quadrature samples, two's complement
//  mute       in   1       level request: 1 = drive midscale, 0 = normal output
//  fmt_obin   in   1       1 = offset-binary output, 0 = two's complement; quasi-static
//  dac_i      out  NCH*DW  registered I to DAC
//  dac_q      out  NCH*DW  registered Q to DAC
//  out_valid  out  1       in_valid delayed by 2 cycles
//  running    out  1       1 in RUN state only
//  state      out  2       0 HOLD, 1 RUN, 2 RAMP (up or down), 3 MUTED
//  heartbeat  out  1       MSB of free-running counter (LED drive)
// BEHAVIOUR
//  Reset: dac_i/dac_q = 0, out_valid = 0, state = HOLD, running = 0, ramp level = 0, heartbeat = 0.
//  Latency: 2 cycles, in -> scaled (register) -> formatted (register); out_valid tracks in_valid at 2.
//  in_valid low: the scaler register holds its last sample (zero-order hold); outputs do not go to zero.
//  Scaling: y = (x * lvl) >>> RAMP_SHIFT, arithmetic shift, truncation toward -inf.
//   - Product is DW+RAMP_SHIFT+1 bits signed.
//   - lvl runs 0 .. 2^RAMP_SHIFT; lvl = 2^RAMP_SHIFT gives exactly y = x; |y| <= |x|, so no saturation.
//  Format: obin = {~y[DW-1], y[DW-2:0]}; midscale is 0 (2C) or 2^(DW-1) (obin).
//  FSM (one decision per cycle):
//   HOLD:  hold counter counts 0..HOLD_CYC-1, lvl = 0, outputs midscale; then -> RUN if !mute, else MUTED.
//   RUN:   lvl = unity; mute=1 -> RAMP (down).
//   RAMP:  lvl moves by 1 per clk toward target (0 if mute, unity if !mute).
//          A mute toggle mid-ramp reverses direction from the current lvl, with no jump.
//          lvl reaches 0 -> MUTED; lvl reaches unity -> RUN.
//   MUTED: lvl = 0, outputs midscale; mute=0 -> RAMP (up).
//  A full ramp takes 2^RAMP_SHIFT cycles. All channels share one lvl and switch on the same cycle.
//  rst mid-ramp or mid-hold: immediate return to reset values; the hold-off restarts.
//  fmt_obin change: takes effect on the next output register update; no glitch suppression.
//  heartbeat: HB_BITS counter, +1 per clk, wraps; heartbeat = cnt[HB_BITS-1].
// CONFIGURATION
//  DAC_RAMP_EN defined: RAMP state is used as above.
//  DAC_RAMP_EN undefined: no RAMP; lvl steps straight between 0 and unity.
//   - RUN->MUTED on the cycle after mute=1; MUTED->RUN on the cycle after mute=0.
//   - state never reports 2; the ramp counter logic is not built.
// STRUCTURE
//  Package tx_out_pkg:
//   - localparams ST_HOLD/ST_RUN/ST_RAMP/ST_MUTED (2-bit)
//   - function midscale(fmt_obin, DW)
//   - function to_obin(y)
//  Sub-module iq_ramp_scaler: one signed DW x (RAMP_SHIFT+1) multiply with shift and register.
//   - generate-instantiated 2*NCH times (I and Q per channel).
//  Top level holds the FSM, hold counter, lvl counter, format/output registers and heartbeat counter.
// TESTING
//  T1 reset/hold: DW=14, HOLD_CYC=16, fmt_obin=1 -> dac = 0x2000 for cycles 1..16; state 0 -> 1 at cycle 17.
//  T2 latency/format: in_i=0x1FFF, in_q=0x2000 (-8192), fmt 2C -> 0x1FFF / 0x2000 2 cycles later.
//     Same input with obin -> 0x3FFF / 0x0000.
//  T3 ramp down (RAMP_EN, RAMP_SHIFT=3): in_i=800 const, mute=1 -> dac_i 700,600,..,0 over 8 cycles;
//     state 2 then 3.
//  T4 mid-ramp reversal: mute=1 for 3 cycles then 0 -> lvl 8,7,6,5,6,7,8; state returns to 1 with no jump.
//  T5 no RAMP_EN: mute=1 -> dac_i = midscale on the 3rd cycle after mute (FSM + 2-stage latency); state 1 -> 3.
//  T6 reset mid-ramp plus NCH=2: rst during RAMP -> all outputs 0 next cycle.
//     After hold-off, ch0/ch1 carry independent samples correctly placed in the packed buses.

Source files
------------

// File: rtl/tx_out_pkg.sv
// -----------------------------------------------------------------------------
// tx_out_pkg
// Shared definitions for the transmitter DAC output stage.
//   ST_*      : 2-bit state codes reported on the state port
//   midscale(): DAC idle code for the selected output format
//   to_obin() : two's complement -> offset binary (MSB flip)
// Both helpers work on a MAX_DW-wide word; callers cast to their own width.
// -----------------------------------------------------------------------------
package tx_out_pkg;

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_RAMP  = 2'd2;
    localparam logic [1:0] ST_MUTED = 2'd3;

    localparam int MAX_DW = 64;

    // Idle code: 0 in two's complement, 2^(dw-1) in offset binary.
    function automatic logic [MAX_DW-1:0] midscale(input logic fmt_obin, input int dw);
        midscale = '0;
        if (fmt_obin)
            midscale[dw-1] = 1'b1;
    endfunction

    function automatic logic [MAX_DW-1:0] to_obin(input logic [MAX_DW-1:0] y, input int dw);
        to_obin        = y;
        to_obin[dw-1]  = ~y[dw-1];
    endfunction

endpackage

// File: rtl/iq_ramp_scaler.sv
// -----------------------------------------------------------------------------
// iq_ramp_scaler
// One signed sample scaled by the shared ramp level and registered:
//   o_y <= (i_x * i_lvl) >>> RAMP_SHIFT   (floor rounding)
// i_lvl spans 0 .. 2^RAMP_SHIFT, so |o_y| <= |i_x| and no saturation is needed.
// Requires RAMP_SHIFT >= 1.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (o_y -> 0)
//   i_en      : load enable; otherwise o_y holds (zero-order hold)
//   i_x       : DW-bit two's complement sample
//   i_lvl     : unsigned level, RAMP_SHIFT+1 bits
//   o_y       : registered scaled sample
// -----------------------------------------------------------------------------
import tx_out_pkg::*;

module iq_ramp_scaler #(
    parameter int DW         = 14,
    parameter int RAMP_SHIFT = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [DW-1:0]         i_x,
    input  logic [RAMP_SHIFT:0]   i_lvl,
    output logic [DW-1:0]         o_y
);

    localparam int PW = DW + RAMP_SHIFT + 1;

    logic signed [PW-1:0] w_x_ext;
    logic signed [PW-1:0] w_lvl_ext;
    logic signed [PW-1:0] w_prod;
    logic                 w_unused_bits;

    assign w_x_ext   = {{(RAMP_SHIFT+1){i_x[DW-1]}}, i_x};
    assign w_lvl_ext = {{DW{1'b0}}, i_lvl};
    assign w_prod    = w_x_ext * w_lvl_ext;

    // Arithmetic shift then truncate to DW is just this slice of the product;
    // the top bit is redundant sign and the low bits are the discarded fraction.
    assign w_unused_bits = ^{w_prod[PW-1], w_prod[RAMP_SHIFT-1:0]};

    always_ff @(posedge clk) begin
        if (rst)
            o_y <= '0;
        else if (i_en)
            o_y <= w_prod[DW+RAMP_SHIFT-1:RAMP_SHIFT];
    end

endmodule

// File: rtl/iq_dac_output_stage.sv
// -----------------------------------------------------------------------------
// iq_dac_output_stage
// Registers NCH I/Q pairs to the DAC with a post-reset hold-off, mute (with an
// optional linear ramp), 2C/offset-binary formatting, a state report and a
// heartbeat. Pipeline: input -> scaler register -> format/output register.
// Build option: define DAC_RAMP_EN for the soft ramp; without it the level
// steps directly between 0 and unity and state never reports RAMP.
// Ports:
//   clk, rst         : DAC clock, synchronous active-high reset
//   in_valid         : new sample on in_i/in_q
//   in_i, in_q       : NCH*DW two's complement samples, ch0 in LSBs
//   mute             : 1 = go to midscale, 0 = normal output
//   fmt_obin         : 1 = offset binary, 0 = two's complement
//   dac_i, dac_q     : registered DAC words
//   out_valid        : in_valid delayed by 2
//   running, state   : RUN flag / state code (HOLD, RUN, RAMP, MUTED)
//   heartbeat        : MSB of a free-running counter
// -----------------------------------------------------------------------------
import tx_out_pkg::*;

module iq_dac_output_stage #(
    parameter int DW         = 14,
    parameter int NCH        = 1,
    parameter int HOLD_CYC   = 4096,
    parameter int RAMP_SHIFT = 6,
    parameter int HB_BITS    = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [NCH*DW-1:0]   in_i,
    input  logic [NCH*DW-1:0]   in_q,
    input  logic                mute,
    input  logic                fmt_obin,
    output logic [NCH*DW-1:0]   dac_i,
    output logic [NCH*DW-1:0]   dac_q,
    output logic                out_valid,
    output logic                running,
    output logic [1:0]          state,
    output logic                heartbeat
);

    localparam int              LW        = RAMP_SHIFT + 1;
    localparam logic [LW-1:0]   UNITY     = {1'b1, {RAMP_SHIFT{1'b0}}};
    localparam logic [LW-1:0]   LVL_ONE   = {{RAMP_SHIFT{1'b0}}, 1'b1};
    localparam int              HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYC - 1);

    logic [1:0]                 r_state, w_state_nxt;
    logic [LW-1:0]              r_lvl, w_lvl_nxt;
    logic [HW-1:0]              r_hold_cnt;
    logic [HB_BITS-1:0]         r_hb_cnt;
    logic [2:1]                 r_vld_pipe;
    logic                       w_scl_en;
    logic [DW-1:0]              w_mid;
    logic [NCH-1:0][DW-1:0]     w_y_i, w_y_q, w_fmt_i, w_fmt_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_HOLD;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HOLD:  if (r_hold_cnt == HOLD_LAST) w_state_nxt = mute ? ST_MUTED : ST_RUN;
`ifdef DAC_RAMP_EN
            ST_RUN:   if (mute) w_state_nxt = ST_RAMP;
            // Direction follows mute every cycle, so a toggle mid-ramp reverses
            // from the current level without a jump.
            ST_RAMP: begin
                if (mute && r_lvl == LVL_ONE)
                    w_state_nxt = ST_MUTED;
                else if (!mute && r_lvl == UNITY - LVL_ONE)
                    w_state_nxt = ST_RUN;
            end
            ST_MUTED: if (!mute) w_state_nxt = ST_RAMP;
`else
            ST_RUN:   if (mute) w_state_nxt = ST_MUTED;
            ST_MUTED: if (!mute) w_state_nxt = ST_RUN;
`endif
            default:  w_state_nxt = ST_HOLD;
        endcase
    end

    always_comb begin
        running = (r_state == ST_RUN);
        state   = r_state;
    end

    // ---------------- level / hold / heartbeat ----------------
    // Level is derived from the state being entered. RAMP is only entered from
    // RUN with mute=1 or from MUTED with mute=0, so +/-1 keeps it in range.
    always_comb begin
        w_lvl_nxt = '0;
        case (w_state_nxt)
            ST_RUN:  w_lvl_nxt = UNITY;
`ifdef DAC_RAMP_EN
            ST_RAMP: w_lvl_nxt = mute ? (r_lvl - LVL_ONE) : (r_lvl + LVL_ONE);
`endif
            default: w_lvl_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl      <= '0;
            r_hold_cnt <= '0;
            r_hb_cnt   <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_lvl      <= w_lvl_nxt;
            r_hb_cnt   <= r_hb_cnt + 1'b1;
            r_vld_pipe <= {r_vld_pipe[1], in_valid};
            if (r_state == ST_HOLD && r_hold_cnt != HOLD_LAST)
                r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign out_valid = r_vld_pipe[2];
    assign heartbeat = r_hb_cnt[HB_BITS-1];

    // ---------------- datapath ----------------
    // At level 0 the scalers reload regardless of in_valid so a held stale
    // sample cannot linger once muted; x*0 forces the register to 0.
    assign w_scl_en = in_valid | (r_lvl == '0);
    assign w_mid    = DW'(midscale(fmt_obin, DW));

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        iq_ramp_scaler #(.DW(DW), .RAMP_SHIFT(RAMP_SHIFT)) u_scl_i (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_scl_en),
            .i_x   (in_i[g*DW +: DW]),
            .i_lvl (r_lvl),
            .o_y   (w_y_i[g])
        );
        iq_ramp_scaler #(.DW(DW), .RAMP_SHIFT(RAMP_SHIFT)) u_scl_q (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_scl_en),
            .i_x   (in_q[g*DW +: DW]),
            .i_lvl (r_lvl),
            .o_y   (w_y_q[g])
        );
    end

    always_comb begin
        w_fmt_i = '0;
        w_fmt_q = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_state == ST_HOLD) begin
                w_fmt_i[c] = w_mid;
                w_fmt_q[c] = w_mid;
            end else if (fmt_obin) begin
                w_fmt_i[c] = DW'(to_obin(MAX_DW'(w_y_i[c]), DW));
                w_fmt_q[c] = DW'(to_obin(MAX_DW'(w_y_q[c]), DW));
            end else begin
                w_fmt_i[c] = w_y_i[c];
                w_fmt_q[c] = w_y_q[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_i <= '0;
            dac_q <= '0;
        end else begin
            dac_i <= w_fmt_i;
            dac_q <= w_fmt_q;
        end
    end

endmodule
